// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB/TRAP. Memory requests use a req/ready
// handshake with a bounded wait. The FSM also detects illegal and misaligned
// instructions and counts retired instructions.
module rv32_mc_ctrl #(
  parameter int MEM_TIMEOUT   = 16,  // wait cycles before bus-error trap, >= 1
  parameter int CNT_W         = 32,
  parameter int TRAP_MISALIGN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [1:0]       addr_lo,
  input  logic             take_branch,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic [2:0]       cpu_state,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             wena_reg,
  output logic [1:0]       data_2_reg,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap_valid,
  output logic [2:0]       trap_cause
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_next;
  logic [CNT_W-1:0]  r_instret;
  logic [2:0]        r_trap_cause;
  logic [2:0]        w_cause_next;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_is_load;
  logic              w_is_store;

  assign cpu_state  = r_state;
  assign instret    = r_instret;
  assign trap_cause = r_trap_cause;
  assign w_is_load  = (opcode == OPC_LOAD);
  assign w_is_store = (opcode == OPC_STORE);

  // Instruction legality and access alignment from the latched IR fields.
  always_comb begin
    w_illegal  = 1'b0;
    w_misalign = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: w_illegal = 1'b0;
      OPC_JALR:   w_illegal = (funct3 != 3'b000);
      OPC_BRANCH: w_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      OPC_LOAD:   w_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      OPC_STORE:  w_illegal = (funct3 >= 3'b011);
      OPC_OP:     w_illegal = !((funct7 == 7'h00) ||
                                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      OPC_OPIMM: begin
        if (funct3 == 3'b001)      w_illegal = (funct7 != 7'h00);
        else if (funct3 == 3'b101) w_illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
        else                       w_illegal = 1'b0;
      end
      default:    w_illegal = 1'b1;
    endcase
    // funct3[1:0] 01 = halfword, 10 = word; byte accesses never misalign
    if ((TRAP_MISALIGN != 0) && (w_is_load || w_is_store)) begin
      w_misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    end
  end

  // Next-state, wait counter and control outputs; everything idles while reset is low.
  always_comb begin
    w_state_next = r_state;
    w_wait_next  = '0;
    w_cause_next = r_trap_cause;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    wena_reg     = 1'b0;
    data_2_reg   = 2'b00;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    retire       = 1'b0;
    trap_valid   = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we        = 1'b1;
            w_state_next = S_DECODE;
          end else if (r_wait == WAIT_LAST) begin
            w_state_next = S_TRAP;
            w_cause_next = 3'd3;
          end else begin
            w_wait_next = r_wait + 1'b1;
          end
        end
        S_DECODE: w_state_next = S_EXEC;
        S_EXEC: begin
          if (w_illegal) begin
            w_state_next = S_TRAP;
            w_cause_next = 3'd0;
          end else if (w_misalign) begin
            w_state_next = S_TRAP;
            w_cause_next = w_is_store ? 3'd2 : 3'd1;
          end else if (opcode == OPC_BRANCH) begin
            pc_we        = 1'b1;
            pc_sel       = take_branch ? 2'b01 : 2'b00;
            retire       = 1'b1;
            w_state_next = S_FETCH;
          end else if (w_is_load || w_is_store) begin
            w_state_next = S_MEM;
          end else begin
            w_state_next = S_WB;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = w_is_store;
          if (dmem_ready) begin
            if (w_is_store) begin
              pc_we        = 1'b1;
              retire       = 1'b1;
              w_state_next = S_FETCH;
            end else begin
              w_state_next = S_WB;
            end
          end else if (r_wait == WAIT_LAST) begin
            w_state_next = S_TRAP;
            w_cause_next = 3'd4;
          end else begin
            w_wait_next = r_wait + 1'b1;
          end
        end
        S_WB: begin
          wena_reg = 1'b1;
          if (w_is_load)                                     data_2_reg = 2'b01;
          else if ((opcode == OPC_JAL) || (opcode == OPC_JALR)) data_2_reg = 2'b10;
          else if (opcode == OPC_LUI)                        data_2_reg = 2'b11;
          pc_we = 1'b1;
          if (opcode == OPC_JAL)       pc_sel = 2'b01;
          else if (opcode == OPC_JALR) pc_sel = 2'b10;
          retire       = 1'b1;
          w_state_next = S_FETCH;
        end
        S_TRAP: begin
          trap_valid   = 1'b1;
          pc_we        = 1'b1;
          pc_sel       = 2'b11;
          w_state_next = S_FETCH;
        end
        default: w_state_next = S_FETCH;
      endcase
    end
  end

  // State, wait counter, retired count and trap cause registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_wait       <= '0;
      r_instret    <= '0;
      r_trap_cause <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      if (retire) r_instret <= r_instret + 1'b1;
      if ((w_state_next == S_TRAP) && (r_state != S_TRAP)) r_trap_cause <= w_cause_next;
    end
  end

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Directed, table-driven bench for rv32_mc_ctrl with hand-computed expectations.
module tb_rv32_mc_ctrl;

  localparam int K_BR = 0, K_WB = 1, K_LD = 2, K_ST = 3, K_TRAP = 4;
  // control vector: {imem_req, ir_we, dmem_req, dmem_we, wena_reg, pc_we, retire, trap_valid}
  localparam logic [7:0] C_IDLE   = 8'h00;
  localparam logic [7:0] C_FWAIT  = 8'h80;
  localparam logic [7:0] C_FRDY   = 8'hC0;
  localparam logic [7:0] C_BR     = 8'h06;
  localparam logic [7:0] C_MLD    = 8'h20;
  localparam logic [7:0] C_MST    = 8'h30;
  localparam logic [7:0] C_MSTRDY = 8'h36;
  localparam logic [7:0] C_WB     = 8'h0E;
  localparam logic [7:0] C_TRAP   = 8'h05;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [1:0] al;
    logic       tb;
    int         fw;     // FETCH cycles before imem_ready
    int         mw;     // MEM cycles before dmem_ready, -1 = never
    int         kind;
    logic [2:0] cause;
    logic [1:0] d2r;
    logic [1:0] psel;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [1:0]  addr_lo = '0;
  logic        take_branch = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic [2:0]  cpu_state;
  logic        imem_req, ir_we, dmem_req, dmem_we, wena_reg, pc_we, retire, trap_valid;
  logic [1:0]  data_2_reg, pc_sel;
  logic [31:0] instret;
  logic [2:0]  trap_cause;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_instret = '0;
  logic [2:0]  exp_cause = '0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  rv32_mc_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32), .TRAP_MISALIGN(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .addr_lo(addr_lo), .take_branch(take_branch), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .cpu_state(cpu_state), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .wena_reg(wena_reg), .data_2_reg(data_2_reg),
    .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire), .instret(instret),
    .trap_valid(trap_valid), .trap_cause(trap_cause)
  );

  function automatic logic [7:0] ctl();
    return {imem_req, ir_we, dmem_req, dmem_we, wena_reg, pc_we, retire, trap_valid};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [1:0] al, input logic tb,
                              input int fw, input int mw, input int kind,
                              input logic [2:0] cause, input logic [1:0] d2r,
                              input logic [1:0] psel);
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.f7 = f7; v.al = al; v.tb = tb;
    v.fw = fw; v.mw = mw; v.kind = kind; v.cause = cause; v.d2r = d2r; v.psel = psel;
    return v;
  endfunction

  task automatic wb_cycle(input vec_t v);
    @(negedge clk); dmem_ready = 1'b0; #1;
    chk({v.name, ".wb_state"}, cpu_state, 4);
    chk({v.name, ".wb_ctl"}, ctl(), C_WB);
    chk({v.name, ".wb_d2r"}, data_2_reg, v.d2r);
    chk({v.name, ".wb_psel"}, pc_sel, v.psel);
    exp_instret++;
  endtask

  task automatic trap_cycle(input vec_t v, input logic [2:0] cause);
    @(negedge clk); dmem_ready = 1'b0; #1;
    chk({v.name, ".trap_state"}, cpu_state, 5);
    chk({v.name, ".trap_ctl"}, ctl(), C_TRAP);
    chk({v.name, ".trap_psel"}, pc_sel, 2'b11);
    chk({v.name, ".trap_cause"}, trap_cause, cause);
    exp_cause = cause;
  endtask

  // One full instruction from its first FETCH cycle to its last cycle.
  task automatic run(input vec_t v);
    for (int k = 0; k <= v.fw; k++) begin
      @(negedge clk);
      opcode = v.op; funct3 = v.f3; funct7 = v.f7; addr_lo = v.al; take_branch = v.tb;
      imem_ready = (k == v.fw); dmem_ready = 1'b0; #1;
      chk({v.name, ".fetch_state"}, cpu_state, 0);
      chk({v.name, ".fetch_ctl"}, ctl(), (k == v.fw) ? C_FRDY : C_FWAIT);
      if (k == 0) begin
        chk({v.name, ".instret"}, instret, exp_instret);
        chk({v.name, ".held_cause"}, trap_cause, exp_cause);
      end
    end
    @(negedge clk); imem_ready = 1'b0; #1;
    chk({v.name, ".decode_state"}, cpu_state, 1);
    chk({v.name, ".decode_ctl"}, ctl(), C_IDLE);
    @(negedge clk); #1;
    chk({v.name, ".exec_state"}, cpu_state, 2);
    if (v.kind == K_BR) begin
      chk({v.name, ".exec_ctl"}, ctl(), C_BR);
      chk({v.name, ".exec_psel"}, pc_sel, v.psel);
      exp_instret++;
    end else begin
      chk({v.name, ".exec_ctl"}, ctl(), C_IDLE);
      if (v.kind == K_TRAP) trap_cycle(v, v.cause);
      else if (v.kind == K_WB) wb_cycle(v);
      else begin
        for (int j = 0; j < ((v.mw < 0) ? 16 : v.mw + 1); j++) begin
          @(negedge clk); dmem_ready = (j == v.mw); #1;
          chk({v.name, ".mem_state"}, cpu_state, 3);
          if (v.kind == K_ST) chk({v.name, ".mem_ctl"}, ctl(), (j == v.mw) ? C_MSTRDY : C_MST);
          else                chk({v.name, ".mem_ctl"}, ctl(), C_MLD);
          if ((v.kind == K_ST) && (j == v.mw)) chk({v.name, ".mem_psel"}, pc_sel, 2'b00);
        end
        if (v.mw < 0)            trap_cycle(v, 3'd4);
        else if (v.kind == K_LD) wb_cycle(v);
        else                     exp_instret++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk("addi",       7'b0010011, 3'b000, 7'h00, 2'b00, 1'b0, 2, 0, K_WB,   3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("lw_al0",     7'b0000011, 3'b010, 7'h00, 2'b00, 1'b0, 0, 4, K_LD,   3'd0, 2'b01, 2'b00));
    vecs.push_back(mk("sh_mis",     7'b0100011, 3'b001, 7'h00, 2'b01, 1'b0, 0, 0, K_TRAP, 3'd2, 2'b00, 2'b00));
    vecs.push_back(mk("bne_taken",  7'b1100011, 3'b001, 7'h00, 2'b00, 1'b1, 1, 0, K_BR,   3'd0, 2'b00, 2'b01));
    vecs.push_back(mk("opc_7f",     7'b1111111, 3'b000, 7'h00, 2'b00, 1'b0, 0, 0, K_TRAP, 3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("beq_nt",     7'b1100011, 3'b000, 7'h00, 2'b00, 1'b0, 0, 0, K_BR,   3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("jal",        7'b1101111, 3'b000, 7'h00, 2'b00, 1'b0, 0, 0, K_WB,   3'd0, 2'b10, 2'b01));
    vecs.push_back(mk("jalr",       7'b1100111, 3'b000, 7'h00, 2'b00, 1'b0, 0, 0, K_WB,   3'd0, 2'b10, 2'b10));
    vecs.push_back(mk("jalr_f3",    7'b1100111, 3'b001, 7'h00, 2'b00, 1'b0, 0, 0, K_TRAP, 3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("lui",        7'b0110111, 3'b000, 7'h00, 2'b00, 1'b0, 0, 0, K_WB,   3'd0, 2'b11, 2'b00));
    vecs.push_back(mk("auipc",      7'b0010111, 3'b000, 7'h00, 2'b00, 1'b0, 0, 0, K_WB,   3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("sub",        7'b0110011, 3'b000, 7'h20, 2'b00, 1'b0, 0, 0, K_WB,   3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("op20_f3_1",  7'b0110011, 3'b001, 7'h20, 2'b00, 1'b0, 0, 0, K_TRAP, 3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("op_f7_01",   7'b0110011, 3'b000, 7'h01, 2'b00, 1'b0, 0, 0, K_TRAP, 3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("srai",       7'b0010011, 3'b101, 7'h20, 2'b00, 1'b0, 0, 0, K_WB,   3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("slli_bad",   7'b0010011, 3'b001, 7'h20, 2'b00, 1'b0, 0, 0, K_TRAP, 3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("lw_mis",     7'b0000011, 3'b010, 7'h00, 2'b10, 1'b0, 0, 0, K_TRAP, 3'd1, 2'b00, 2'b00));
    vecs.push_back(mk("lhu_al2",    7'b0000011, 3'b101, 7'h00, 2'b10, 1'b0, 0, 0, K_LD,   3'd0, 2'b01, 2'b00));
    vecs.push_back(mk("lh_mis",     7'b0000011, 3'b001, 7'h00, 2'b11, 1'b0, 0, 0, K_TRAP, 3'd1, 2'b00, 2'b00));
    vecs.push_back(mk("load_f3_3",  7'b0000011, 3'b011, 7'h00, 2'b01, 1'b0, 0, 0, K_TRAP, 3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("sw",         7'b0100011, 3'b010, 7'h00, 2'b00, 1'b0, 0, 1, K_ST,   3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("sb_al3",     7'b0100011, 3'b000, 7'h00, 2'b11, 1'b0, 0, 0, K_ST,   3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("store_f3_3", 7'b0100011, 3'b011, 7'h00, 2'b00, 1'b0, 0, 0, K_TRAP, 3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("branch_f3_2",7'b1100011, 3'b010, 7'h00, 2'b00, 1'b0, 0, 0, K_TRAP, 3'd0, 2'b00, 2'b00));
    vecs.push_back(mk("lb_al3",     7'b0000011, 3'b000, 7'h00, 2'b11, 1'b0, 0, 0, K_LD,   3'd0, 2'b01, 2'b00));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", cpu_state, 0);
    chk("reset_ctl", ctl(), C_IDLE);
    chk("reset_instret", instret, 0);
    chk("reset_cause", trap_cause, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      run(vecs[i]);
      $display("vec %0d %s done checks=%0d errors=%0d", i, vecs[i].name, n_checks, n_errors);
    end

    // imem never ready: 16 FETCH cycles then bus-error trap; stray dmem_ready ignored
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'h00;
      imem_ready = 1'b0; dmem_ready = 1'b1; #1;
      chk("imem_to.fetch_state", cpu_state, 0);
      chk("imem_to.fetch_ctl", ctl(), C_FWAIT);
    end
    trap_cycle(vecs[0], 3'd3);
    $display("seq imem_timeout done checks=%0d errors=%0d", n_checks, n_errors);

    // Ready on the 16th FETCH cycle wins over the timeout
    run(mk("addi_rdy16", 7'b0010011, 3'b000, 7'h00, 2'b00, 1'b0, 15, 0, K_WB, 3'd0, 2'b00, 2'b00));
    $display("seq ready_on_16 done checks=%0d errors=%0d", n_checks, n_errors);

    // dmem never ready on a load
    run(mk("lw_dmem_to", 7'b0000011, 3'b010, 7'h00, 2'b00, 1'b0, 0, -1, K_LD, 3'd4, 2'b01, 2'b00));
    $display("seq dmem_timeout done checks=%0d errors=%0d", n_checks, n_errors);

    // Reset during the MEM wait of a SW
    @(negedge clk);
    opcode = 7'b0100011; funct3 = 3'b010; funct7 = 7'h00; addr_lo = 2'b00; imem_ready = 1'b1;
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk); #1;
    chk("rst_sw.exec_state", cpu_state, 2);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk); #1;
      chk("rst_sw.mem_state", cpu_state, 3);
      chk("rst_sw.mem_ctl", ctl(), C_MST);
    end
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rst_sw.during_ctl", ctl(), C_IDLE);
    @(negedge clk); #1;
    chk("rst_sw.state", cpu_state, 0);
    chk("rst_sw.ctl", ctl(), C_IDLE);
    chk("rst_sw.instret", instret, 0);
    chk("rst_sw.cause", trap_cause, 0);
    exp_instret = '0;
    exp_cause   = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    run(vecs[0]);
    @(negedge clk); #1;
    chk("post_rst.instret", instret, exp_instret);
    $display("seq reset_mid_mem done checks=%0d errors=%0d", n_checks, n_errors);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
